trail_rmw_sched: RTL and testbench

TRAIL_RMW_SCHED -- requirements
Module: trail_rmw_sched

---
 rtl/trail_pkg.sv | 14 +
 rtl/rmw_scoreboard.sv | 50 +++++
 rtl/trail_rmw_sched.sv | 177 +++++++++++++++++
 tb/tb_trail_rmw_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trail_pkg.sv
// Shared definitions for the trail effect: frame-buffer geometry and scheduler states.
package trail_pkg;

  localparam int COLOR_DEPTH = 8;
  localparam int FB_DEPTH    = 76800;   // 320 x 240 history entries
  localparam int FB_ADDR_W   = 17;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rmw_scoreboard.sv
// In-flight tracker: a shift register of {valid, addr} covering every pixel
// from acceptance until its history write retires from the last stage.
module rmw_scoreboard #(
  parameter int N      = 6,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_valid,
  input  logic [ADDR_W-1:0] shift_addr,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              match,
  output logic [N-1:0]      valid_vec,
  output logic [ADDR_W-1:0] head_addr,
  output logic              retire_valid,
  output logic [ADDR_W-1:0] retire_addr
);

  logic [N-1:0]      valid_reg;
  logic [ADDR_W-1:0] addr_reg [N];
  logic [N-2:0]      hit;

  // Advance every entry one stage per cycle; a new entry enters stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < N; i++) addr_reg[i] <= '0;
    end else begin
      valid_reg   <= {valid_reg[N-2:0], shift_valid};
      addr_reg[0] <= shift_addr;
      for (int i = 1; i < N; i++) addr_reg[i] <= addr_reg[i-1];
    end
  end

  // The last stage is writing this cycle, so its address is already safe to read
  // again next cycle; only stages 0..N-2 take part in the hazard compare.
  genvar gi;
  generate
    for (gi = 0; gi < N-1; gi++) begin : g_cmp
      assign hit[gi] = valid_reg[gi] && (addr_reg[gi] == cmp_addr);
    end
  endgenerate

  assign match        = |hit;
  assign valid_vec    = valid_reg;
  assign head_addr    = addr_reg[0];
  assign retire_valid = valid_reg[N-1];
  assign retire_addr  = addr_reg[N-1];

endmodule

// File: rtl/trail_rmw_sched.sv
// Read-modify-write scheduler for the trail history buffer: reads the old value,
// hands it to the IIR with the camera pixel, and writes the result back while
// stalling any pixel whose address is still in flight.
module trail_rmw_sched #(
  parameter int COLOR_DEPTH = trail_pkg::COLOR_DEPTH,
  parameter int DEPTH       = trail_pkg::FB_DEPTH,
  parameter int ADDR_W      = trail_pkg::FB_ADDR_W,
  parameter int RD_LAT      = 2,
  parameter int IIR_LAT     = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   cam_valid_in,
  output logic                   cam_ready_out,
  input  logic [ADDR_W-1:0]      cam_addr_in,
  input  logic [COLOR_DEPTH-1:0] cam_pxl_in,
  input  logic                   clear_in,
  output logic                   busy_out,
  output logic                   rd_en_out,
  output logic [ADDR_W-1:0]      rd_addr_out,
  input  logic [COLOR_DEPTH-1:0] rd_data_in,
  output logic                   iir_valid_out,
  output logic [COLOR_DEPTH-1:0] iir_hist_out,
  output logic [COLOR_DEPTH-1:0] iir_cam_out,
  input  logic                   iir_valid_in,
  input  logic [COLOR_DEPTH-1:0] iir_upd_in,
  output logic                   wr_en_out,
  output logic [ADDR_W-1:0]      wr_addr_out,
  output logic [COLOR_DEPTH-1:0] wr_data_out,
  output logic [15:0]            stall_cnt_out,
  output logic                   err_out
);

  import trail_pkg::*;

  localparam int N       = RD_LAT + IIR_LAT + 2;
  localparam int EXP_IDX = RD_LAT + IIR_LAT;     // stage whose result is due from the IIR
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic rst_meta_reg, rst_sync_reg, rst_n_int;

  sched_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

  logic              cam_ready, xfer, in_range, hazard, any_valid;
  logic [N-1:0]      valid_vec;
  logic [ADDR_W-1:0] head_addr, retire_addr;
  logic              retire_valid;

  logic [15:0]            stall_cnt_reg;
  logic                   err_reg;
  logic                   upd_ok_reg;
  logic [COLOR_DEPTH-1:0] upd_reg;
  logic [COLOR_DEPTH-1:0] pxl_pipe_reg [RD_LAT+1];

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= rst_meta_reg;
    end
  end
  assign rst_n_int = rst_sync_reg;

  // Out-of-range pixels complete the handshake but are never tracked.
  assign in_range = {1'b0, cam_addr_in} < DEPTH_W;
  assign xfer     = cam_valid_in & cam_ready;

  rmw_scoreboard #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk          (clk_in),
    .rst_n        (rst_n_int),
    .shift_valid  (xfer & in_range),
    .shift_addr   (cam_addr_in),
    .cmp_addr     (cam_addr_in),
    .match        (hazard),
    .valid_vec    (valid_vec),
    .head_addr    (head_addr),
    .retire_valid (retire_valid),
    .retire_addr  (retire_addr)
  );

  assign any_valid = |valid_vec;

  // Scheduler state and clear-address register.
  always_ff @(posedge clk_in or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Next-state and handshake decode; the clear counter parks at the last address.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    cam_ready    = 1'b0;
    unique case (state_reg)
      RUN: begin
        cam_ready = ~hazard;
        if (clear_in) state_next = DRAIN;
      end
      DRAIN: begin
        clr_cnt_next = '0;
        if (!any_valid) state_next = CLEAR;
      end
      CLEAR: begin
        if (clr_cnt_reg == LAST_ADDR) state_next = RUN;
        else clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
      end
      default: state_next = CLEAR;
    endcase
  end

  // Stall counter, sticky slot error and the registered IIR result.
  always_ff @(posedge clk_in or negedge rst_n_int) begin
    if (!rst_n_int) begin
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
      upd_ok_reg    <= 1'b0;
      upd_reg       <= '0;
    end else begin
      if (cam_valid_in && hazard && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (iir_valid_in != valid_vec[EXP_IDX])
        err_reg <= 1'b1;
      upd_ok_reg <= iir_valid_in & valid_vec[EXP_IDX];
      if (iir_valid_in && valid_vec[EXP_IDX])
        upd_reg <= iir_upd_in;
    end
  end

  // Camera pixel delay line, aligned with the history read data.
  always_ff @(posedge clk_in or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int i = 0; i <= RD_LAT; i++) pxl_pipe_reg[i] <= '0;
    end else begin
      pxl_pipe_reg[0] <= cam_pxl_in;
      for (int i = 1; i <= RD_LAT; i++) pxl_pipe_reg[i] <= pxl_pipe_reg[i-1];
    end
  end

  assign cam_ready_out = cam_ready;
  assign busy_out      = (state_reg != RUN);
  assign rd_en_out     = valid_vec[0] & (state_reg != CLEAR);
  assign rd_addr_out   = head_addr;
  assign iir_valid_out = valid_vec[RD_LAT] & (state_reg != CLEAR);
  assign iir_hist_out  = iir_valid_out ? rd_data_in : '0;
  assign iir_cam_out   = iir_valid_out ? pxl_pipe_reg[RD_LAT] : '0;
  assign stall_cnt_out = stall_cnt_reg;
  assign err_out       = err_reg;

  // Write port: zero-fill while clearing, otherwise the retiring update.
  always_comb begin
    wr_en_out   = 1'b0;
    wr_addr_out = '0;
    wr_data_out = '0;
    if (state_reg == CLEAR) begin
      wr_en_out   = rst_n_int;
      wr_addr_out = clr_cnt_reg;
    end else if (upd_ok_reg && retire_valid) begin
      wr_en_out   = 1'b1;
      wr_addr_out = retire_addr;
      wr_data_out = upd_reg;
    end
  end

endmodule

// File: tb/tb_trail_rmw_sched.sv
// Directed bench for trail_rmw_sched with a 2-cycle BRAM model and a 2-cycle
// averaging IIR model (out = (hist + cam) / 2).
module tb_trail_rmw_sched;

  localparam int CD    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          cam_valid_in = 1'b0;
  logic          cam_ready_out;
  logic [AW-1:0] cam_addr_in = '0;
  logic [CD-1:0] cam_pxl_in = '0;
  logic          clear_in = 1'b0;
  logic          busy_out;
  logic          rd_en_out;
  logic [AW-1:0] rd_addr_out;
  logic [CD-1:0] rd_data_in;
  logic          iir_valid_out;
  logic [CD-1:0] iir_hist_out, iir_cam_out;
  logic          iir_valid_in;
  logic [CD-1:0] iir_upd_in;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [CD-1:0] wr_data_out;
  logic [15:0]   stall_cnt_out;
  logic          err_out;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  trail_rmw_sched #(
    .COLOR_DEPTH (CD), .DEPTH (DEPTH), .ADDR_W (AW), .RD_LAT (2), .IIR_LAT (2)
  ) dut (
    .clk_in (clk_in), .rst_in (rst_in),
    .cam_valid_in (cam_valid_in), .cam_ready_out (cam_ready_out),
    .cam_addr_in (cam_addr_in), .cam_pxl_in (cam_pxl_in),
    .clear_in (clear_in), .busy_out (busy_out),
    .rd_en_out (rd_en_out), .rd_addr_out (rd_addr_out), .rd_data_in (rd_data_in),
    .iir_valid_out (iir_valid_out), .iir_hist_out (iir_hist_out), .iir_cam_out (iir_cam_out),
    .iir_valid_in (iir_valid_in), .iir_upd_in (iir_upd_in),
    .wr_en_out (wr_en_out), .wr_addr_out (wr_addr_out), .wr_data_out (wr_data_out),
    .stall_cnt_out (stall_cnt_out), .err_out (err_out)
  );

  // BRAM model, two-cycle read latency
  logic [CD-1:0] mem [32];
  logic [CD-1:0] rd_p1, rd_p2;
  always @(posedge clk_in) begin
    if (wr_en_out) mem[wr_addr_out] <= wr_data_out;
    if (rd_en_out) rd_p1 <= mem[rd_addr_out];
    rd_p2 <= rd_p1;
  end
  assign rd_data_in = rd_p2;

  // IIR model, two-cycle latency; spur injects an unexpected valid
  logic          iv1, iv2, spur = 1'b0;
  logic [CD-1:0] id1, id2;
  logic [CD:0]   iir_sum;
  assign iir_sum = {1'b0, iir_hist_out} + {1'b0, iir_cam_out};
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      iv1 <= 1'b0; iv2 <= 1'b0; id1 <= '0; id2 <= '0;
    end else begin
      iv1 <= iir_valid_out; id1 <= iir_sum[CD:1];
      iv2 <= iv1;           id2 <= id1;
    end
  end
  assign iir_valid_in = iv2 | spur;
  assign iir_upd_in   = id2;

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_out !== 1'b0 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy_out=%b after %0d cycles, required 0", name, busy_out, n);
    end
  endtask

  task automatic hard_reset(input string name);
    cam_valid_in = 1'b0; clear_in = 1'b0;
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    wait_idle(name);
  endtask

  task automatic test_reset();
    int nw = 0, bad = 0, n = 0;
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    checks++;
    if ({wr_en_out, rd_en_out, iir_valid_out, cam_ready_out} !== 4'b0) begin
      errors++;
      $display("FAIL reset strobes: wr/rd/iir/ready=%b, required 0000",
               {wr_en_out, rd_en_out, iir_valid_out, cam_ready_out});
    end
    checks++;
    if (stall_cnt_out !== 16'd0 || err_out !== 1'b0) begin
      errors++;
      $display("FAIL reset status: stall=%0d err=%b, required 0 0", stall_cnt_out, err_out);
    end
    checks++;
    if ({wr_addr_out, rd_addr_out, wr_data_out, iir_hist_out, iir_cam_out} !== '0) begin
      errors++;
      $display("FAIL reset data: wr_addr=%0d rd_addr=%0d wr_data=%h hist=%h cam=%h, required all 0",
               wr_addr_out, rd_addr_out, wr_data_out, iir_hist_out, iir_cam_out);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    while (n < 60) begin
      #1;
      if (wr_en_out === 1'b1) begin
        if (busy_out !== 1'b1 || wr_addr_out !== nw[AW-1:0] || wr_data_out !== 8'h00) bad++;
        nw++;
      end else if (busy_out === 1'b0) begin
        break;
      end
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (nw !== 16 || bad !== 0) begin
      errors++;
      $display("FAIL reset clear: writes=%0d bad=%0d, required 16 0", nw, bad);
    end
    checks++;
    if (cam_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset ready: ready=%b busy=%b, required 1 0", cam_ready_out, busy_out);
    end
    $display("test_reset: %0d clear writes", nw);
  endtask

  task automatic test_single_pixel();
    int rd_k = -1, iv_k = -1, wr_k = -1;
    logic [AW-1:0] rd_a = '0, wr_a = '0;
    logic [CD-1:0] h = '0, c = '0, wd = '0;
    hard_reset("single");
    cam_valid_in = 1'b1; cam_addr_in = 5'd5; cam_pxl_in = 8'h80;
    #1;
    checks++;
    if (cam_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL single ready: ready=%b, required 1", cam_ready_out);
    end
    @(negedge clk_in);
    cam_valid_in = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      #1;
      if (rd_en_out === 1'b1 && rd_k < 0) begin rd_k = k; rd_a = rd_addr_out; end
      if (iir_valid_out === 1'b1 && iv_k < 0) begin iv_k = k; h = iir_hist_out; c = iir_cam_out; end
      if (wr_en_out === 1'b1 && wr_k < 0) begin wr_k = k; wr_a = wr_addr_out; wd = wr_data_out; end
      @(negedge clk_in);
    end
    checks++;
    if (rd_k != 1 || rd_a !== 5'd5) begin
      errors++;
      $display("FAIL single rd: cycle=%0d addr=%0d, required 1 5", rd_k, rd_a);
    end
    checks++;
    if (iv_k != 3 || h !== 8'h00 || c !== 8'h80) begin
      errors++;
      $display("FAIL single iir: cycle=%0d hist=%h cam=%h, required 3 00 80", iv_k, h, c);
    end
    checks++;
    if (wr_k != 6 || wr_a !== 5'd5 || wd !== 8'h40) begin
      errors++;
      $display("FAIL single wr: cycle=%0d addr=%0d data=%h, required 6 5 40", wr_k, wr_a, wd);
    end
    $display("test_single_pixel: rd@%0d iir@%0d wr@%0d data=%h", rd_k, iv_k, wr_k, wd);
  endtask

  task automatic test_back_to_back();
    int acc = 0, t1 = -1, t2 = -1, nwr = 0, w1k = -1;
    logic [CD-1:0] wlast = '0;
    hard_reset("b2b");
    cam_valid_in = 1'b1; cam_addr_in = 5'd5; cam_pxl_in = 8'h80;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (wr_en_out === 1'b1) begin
        nwr++; wlast = wr_data_out;
        if (w1k < 0) w1k = k;
      end
      if (cam_valid_in && cam_ready_out === 1'b1) begin
        if (acc == 0) t1 = k; else t2 = k;
        acc++;
      end
      @(negedge clk_in);
      if (acc == 2) cam_valid_in = 1'b0;
    end
    checks++;
    if (acc != 2 || t2 - t1 != 6) begin
      errors++;
      $display("FAIL b2b accept: transfers=%0d gap=%0d, required 2 6", acc, t2 - t1);
    end
    checks++;
    if (w1k != t2) begin
      errors++;
      $display("FAIL b2b order: first write cycle=%0d second accept=%0d, required equal", w1k, t2);
    end
    checks++;
    if (stall_cnt_out !== 16'd5) begin
      errors++;
      $display("FAIL b2b stall: stall_cnt=%0d, required 5", stall_cnt_out);
    end
    checks++;
    if (nwr != 2 || wlast !== 8'h60) begin
      errors++;
      $display("FAIL b2b data: writes=%0d last=%h, required 2 60", nwr, wlast);
    end
    $display("test_back_to_back: gap=%0d stall=%0d last=%h", t2 - t1, stall_cnt_out, wlast);
  endtask

  task automatic test_clear_inflight();
    logic [AW-1:0] wa [32];
    logic [CD-1:0] wd [32];
    logic [CD-1:0] exp_d [3];
    int nw = 0, ready_bad = 0, not_ready = 0;
    exp_d[0] = 8'h08; exp_d[1] = 8'h10; exp_d[2] = 8'h18;
    for (int i = 0; i < 3; i++) begin
      cam_valid_in = 1'b1; cam_addr_in = AW'(1 + i); cam_pxl_in = CD'(16 * (i + 1));
      #1;
      if (cam_ready_out !== 1'b1) not_ready++;
      @(negedge clk_in);
    end
    cam_valid_in = 1'b0;
    checks++;
    if (not_ready != 0) begin
      errors++;
      $display("FAIL clear accept: %0d of 3 pixels refused, required 0", not_ready);
    end
    clear_in = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (wr_en_out === 1'b1 && nw < 32) begin wa[nw] = wr_addr_out; wd[nw] = wr_data_out; nw++; end
      if (k >= 1 && busy_out === 1'b0) break;
      if (k >= 1 && cam_ready_out !== 1'b0) ready_bad++;
      @(negedge clk_in);
      clear_in = 1'b0;
    end
    clear_in = 1'b0;
    checks++;
    if (nw != 19 || ready_bad != 0) begin
      errors++;
      $display("FAIL clear count: writes=%0d ready_high=%0d, required 19 0", nw, ready_bad);
    end
    for (int i = 0; i < 19 && i < nw; i++) begin
      logic [AW-1:0] ea;
      logic [CD-1:0] ed;
      ea = (i < 3) ? AW'(i + 1) : AW'(i - 3);
      ed = (i < 3) ? exp_d[i] : 8'h00;
      checks++;
      if (wa[i] !== ea || wd[i] !== ed) begin
        errors++;
        $display("FAIL clear write %0d: addr=%0d data=%h, required %0d %h", i, wa[i], wd[i], ea, ed);
      end
    end
    $display("test_clear_inflight: %0d writes", nw);
  endtask

  task automatic test_out_of_range();
    int seen = 0;
    cam_valid_in = 1'b1; cam_addr_in = 5'd20; cam_pxl_in = 8'hAA;
    #1;
    checks++;
    if (cam_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL oor ready: ready=%b, required 1", cam_ready_out);
    end
    @(negedge clk_in);
    cam_valid_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (rd_en_out === 1'b1 || iir_valid_out === 1'b1 || wr_en_out === 1'b1) seen++;
      @(negedge clk_in);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL oor activity: %0d strobe cycles, required 0", seen);
    end
    $display("test_out_of_range: strobe cycles=%0d", seen);
  endtask

  task automatic test_spurious_iir();
    int nwr = 0;
    #1;
    checks++;
    if (err_out !== 1'b0) begin
      errors++;
      $display("FAIL spur before: err=%b, required 0", err_out);
    end
    @(negedge clk_in);
    spur = 1'b1;
    @(negedge clk_in);
    spur = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (wr_en_out === 1'b1) nwr++;
      if (k == 1) begin
        checks++;
        if (err_out !== 1'b1) begin
          errors++;
          $display("FAIL spur set: err=%b, required 1", err_out);
        end
      end
      @(negedge clk_in);
    end
    #1;
    checks++;
    if (err_out !== 1'b1 || nwr != 0) begin
      errors++;
      $display("FAIL spur sticky: err=%b writes=%0d, required 1 0", err_out, nwr);
    end
    $display("test_spurious_iir: err=%b writes=%0d", err_out, nwr);
  endtask

  task automatic test_reset_midflight();
    int nw = 0, bad = 0;
    cam_valid_in = 1'b1; cam_addr_in = 5'd7; cam_pxl_in = 8'hFE;
    #1;
    checks++;
    if (cam_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rstmid ready: ready=%b, required 1", cam_ready_out);
    end
    @(negedge clk_in);
    cam_valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checks++;
    if ({wr_en_out, rd_en_out, iir_valid_out, cam_ready_out} !== 4'b0 ||
        stall_cnt_out !== 16'd0 || err_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid assert: strobes=%b stall=%0d err=%b, required 0000 0 0",
               {wr_en_out, rd_en_out, iir_valid_out, cam_ready_out}, stall_cnt_out, err_out);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (wr_en_out === 1'b1) begin
        if (wr_addr_out !== nw[AW-1:0] || wr_data_out !== 8'h00) bad++;
        nw++;
      end else if (busy_out === 1'b0) begin
        break;
      end
      @(negedge clk_in);
    end
    checks++;
    if (nw != 16 || bad != 0) begin
      errors++;
      $display("FAIL rstmid clear: writes=%0d bad=%0d, required 16 0", nw, bad);
    end
    checks++;
    if (stall_cnt_out !== 16'd0 || err_out !== 1'b0 || cam_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rstmid after: stall=%0d err=%b ready=%b, required 0 0 1",
               stall_cnt_out, err_out, cam_ready_out);
    end
    $display("test_reset_midflight: %0d clear writes, stall=%0d", nw, stall_cnt_out);
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_clear_inflight();
    test_out_of_range();
    test_spurious_iir();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
